qoa_spi_frontend: RTL and testbench

SPI slave front-end for the QOA decoder core, between the chip's SPI pins and the decoder. It synchronises the SPI pins into `sys_clk` and deserialises MOSI into bytes, presented as a one-cycle `data_rdy` strobe with the byte. It also serialises the decoder's 16-bit sample word onto MISO after a sample-TX command byte. SPI mode 0 only (CPOL=0, CPHA=0), MSB first.

---
 rtl/qoa_spi_frontend.sv | 98 +++++++++
 tb/tb_qoa_spi_frontend.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/qoa_spi_frontend.sv
// qoa_spi_frontend: SPI mode-0 slave front-end, RX byte strobe and 16-bit sample TX for the QOA decoder
module qoa_spi_frontend #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [15:0] tx_word,
    output logic [7:0]  rx_byte,
    output logic        data_rdy
);
    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} tx_state_t;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_prev, sck_s, cs_s, mosi_s;
    logic                   rise, fall, done, cmd;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_sr;
    logic [15:0]            tx_sr;
    logic [3:0]             tx_cnt;
    tx_state_t              state, state_next;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign rise   = sck_s & ~sck_prev & ~cs_s;
    assign fall   = ~sck_s & sck_prev & ~cs_s;
    assign cmd    = data_rdy & rx_byte[7] & ~rx_byte[0];

    // pin synchronisers, preset to the idle bus state, plus the sck edge-detect copy
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_prev  <= sck_s;
        end
    end

    // receive shifter; a byte completes on the 8th rise and is published one cycle later
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_sr    <= '0;
            bit_cnt  <= '0;
            done     <= 1'b0;
            data_rdy <= 1'b0;
            rx_byte  <= '0;
        end else begin
            done     <= rise && bit_cnt == 3'd7;
            data_rdy <= done;
            if (done)
                rx_byte <= rx_sr;
            if (cs_s)
                bit_cnt <= '0;
            else if (rise) begin
                rx_sr   <= {rx_sr[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // tx state register, sample shifter and registered miso
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            tx_sr    <= '0;
            tx_cnt   <= '0;
            spi_miso <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ARMED && fall) begin
                tx_sr  <= tx_word;
                tx_cnt <= 4'd15;
            end else if (state == SHIFT && fall && tx_cnt != 4'd0) begin
                tx_sr  <= tx_sr << 1;
                tx_cnt <= tx_cnt - 4'd1;
            end
            spi_miso <= (state == SHIFT && !cs_s && !(fall && tx_cnt == 4'd0)) ? tx_sr[15] : 1'b0;
        end
    end

    // tx next state: cs release always wins, commands only accepted from idle
    always_comb begin
        state_next = cs_s                                   ? IDLE  :
                     (state == IDLE  && cmd)                ? ARMED :
                     (state == ARMED && fall)               ? SHIFT :
                     (state == SHIFT && fall && tx_cnt == 4'd0) ? IDLE :
                     state;
    end
endmodule

// File: tb/tb_qoa_spi_frontend.sv
// tb_qoa_spi_frontend: directed checks of RX strobes, sample TX, aborts and reset
module tb_qoa_spi_frontend;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [15:0] tx_word = 16'h0000;
    logic [7:0]  rx_byte;
    logic        data_rdy;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rise_cyc = 0;
    int          strobe_cyc = 0;
    int          dbl = 0;
    logic        prev_rdy = 1'b0;
    logic [7:0]  q[$];
    logic [7:0]  m0, m1;

    qoa_spi_frontend #(.SYNC_STAGES(2)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .spi_sck (spi_sck),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .tx_word (tx_word),
        .rx_byte (rx_byte),
        .data_rdy(data_rdy)
    );

    always #5 sys_clk = ~sys_clk;

    // cycle count used to time strobes against sck rises
    always @(posedge sys_clk) cyc++;

    // strobe monitor: log each received byte and flag back-to-back strobes
    always @(negedge sys_clk) begin
        if (data_rdy) begin
            q.push_back(rx_byte);
            strobe_cyc = cyc;
            if (prev_rdy) dbl++;
        end
        prev_rdy = data_rdy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cs_low();
        @(negedge sys_clk) spi_cs_n = 1'b0;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic cs_high();
        @(negedge sys_clk) spi_cs_n = 1'b1;
        repeat (6) @(negedge sys_clk);
    endtask

    // send the top n bits of b at sys_clk/8, returning miso sampled just before each rise
    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] m);
        m = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = b[7-i];
            repeat (4) @(negedge sys_clk);
            m = {m[6:0], spi_miso};
            spi_sck = 1'b1;
            rise_cyc = cyc;
            repeat (4) @(negedge sys_clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (8) @(negedge sys_clk);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_miso", spi_miso, 0);
        chk("rst_rdy", data_rdy, 0);
        chk("rst_rx", rx_byte, 8'h00);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);

        // asynchronous reset in the middle of a byte
        cs_low();
        send_bits(8'h5A, 8, m0);
        settle();
        chk("pre_rst_rx", rx_byte, 8'h5A);
        send_bits(8'hF0, 4, m0);
        #2 sys_rst = 1'b1;
        #1;
        chk("mid_rst_miso", spi_miso, 0);
        chk("mid_rst_rdy", data_rdy, 0);
        chk("mid_rst_rx", rx_byte, 8'h00);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);

        // single byte after reset, strobe latency from the 8th rise
        q.delete();
        cs_low();
        send_bits(8'hA5, 8, m0);
        settle();
        chk("a5_count", q.size(), 1);
        chk("a5_byte", q[0], 8'hA5);
        chk("a5_latency", strobe_cyc - rise_cyc, 4);
        chk("a5_hold", rx_byte, 8'hA5);
        cs_high();

        // back-to-back bytes in one frame
        q.delete();
        cs_low();
        send_bits(8'h13, 8, m0);
        send_bits(8'h7F, 8, m0);
        send_bits(8'h00, 8, m0);
        settle();
        chk("b2b_count", q.size(), 3);
        chk("b2b_0", q[0], 8'h13);
        chk("b2b_1", q[1], 8'h7F);
        chk("b2b_2", q[2], 8'h00);
        cs_high();

        // sample tx: 0x80 then 16 clocks read back 0xBEEF
        q.delete();
        tx_word = 16'h0000;
        cs_low();
        fork
            send_bits(8'h80, 8, m0);
            begin
                int k;
                for (k = 0; k < 200 && !data_rdy; k++) @(negedge sys_clk);
                chk("cmd_strobe_wait", k < 200, 1);
                @(negedge sys_clk) tx_word = 16'hBEEF;
            end
        join
        chk("cmd_miso_idle", m0, 8'h00);
        send_bits(8'h00, 8, m0);
        send_bits(8'h00, 8, m1);
        chk("tx_word", {m0, m1}, 16'hBEEF);
        settle();
        chk("tx_miso_end", spi_miso, 0);
        chk("tx_count", q.size(), 3);
        chk("tx_rx1", q[1], 8'h00);
        chk("tx_rx2", q[2], 8'h00);

        // non-tx commands leave miso quiet
        tx_word = 16'hFFFF;
        send_bits(8'h01, 8, m0);
        send_bits(8'h00, 8, m0);
        send_bits(8'h00, 8, m1);
        chk("cmd01_miso", {m0, m1}, 16'h0000);
        send_bits(8'h02, 8, m0);
        send_bits(8'h00, 8, m0);
        send_bits(8'h00, 8, m1);
        chk("cmd02_miso", {m0, m1}, 16'h0000);
        cs_high();

        // abort after 5 bits, then a clean byte
        q.delete();
        cs_low();
        send_bits(8'hFF, 5, m0);
        cs_high();
        cs_low();
        send_bits(8'h3C, 8, m0);
        settle();
        chk("abort_count", q.size(), 1);
        chk("abort_byte", q[0], 8'h3C);

        // cs release during shift forces miso low and the fsm back to idle
        send_bits(8'h80, 8, m0);
        send_bits(8'h00, 3, m0);
        repeat (5) @(negedge sys_clk);
        chk("shift_miso_hi", spi_miso, 1);
        cs_high();
        chk("cs_miso", spi_miso, 0);
        cs_low();
        send_bits(8'h00, 8, m0);
        send_bits(8'h00, 8, m1);
        chk("cs_idle_miso", {m0, m1}, 16'h0000);
        cs_high();

        // cs rising together with the 8th sck rise
        q.delete();
        cs_low();
        send_bits(8'h66, 8, m0);
        send_bits(8'h55, 7, m0);
        spi_mosi = 1'b1;
        repeat (4) @(negedge sys_clk);
        spi_sck = 1'b1;
        spi_cs_n = 1'b1;
        settle();
        spi_sck = 1'b0;
        settle();
        chk("race_count", q.size(), 1);
        chk("race_rx", rx_byte, 8'h66);

        chk("no_double_rdy", dbl, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // overall time bound
    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout got=running exp=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
